// File: rtl/apb_pkg.sv
// Shared definitions for the APB multi-slave subsystem.
//   apb_state_e : master FSM state encoding (IDLE / SETUP / ACCESS)
//   clog2       : ceiling log2, never smaller than 1 so derived widths stay legal
//   STRB_WIDTH, SEL_WIDTH, OFF_WIDTH : widths for the default configuration
//                 (32-bit data, 4 slaves, 32 words per slave); parameterised
//                 modules derive their own copies from their parameters.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SLAVES = 4;
    localparam int DEF_SLV_DEPTH  = 32;

    localparam int STRB_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int SEL_WIDTH  = clog2(DEF_NUM_SLAVES);
    localparam int OFF_WIDTH  = clog2(DEF_SLV_DEPTH);

endpackage

// File: rtl/apb_mem_slave.sv
// Memory-backed APB slave with a fixed number of ACCESS-phase wait states.
// Ports:
//   apb_clk, apb_reset      : clock, synchronous active-high reset (clears memory)
//   psel, penable, pwrite   : APB control from the master
//   paddr [OFF_W]           : word offset inside this slave
//   pwdata, pstrb           : write data and byte enables
//   prdata, pready, pslverr : read data, ready (wait counter at 0), error (always 0)
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  SLV_DEPTH   = 32,
    parameter int  WAIT_STATES = 1,
    localparam int STRB_W      = DATA_WIDTH / 8,
    localparam int OFF_W       = clog2(SLV_DEPTH)
) (
    input  logic                  apb_clk,
    input  logic                  apb_reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [OFF_W-1:0]      paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_W-1:0]     pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    logic [DATA_WIDTH-1:0] mem [SLV_DEPTH];
    logic [3:0]            wait_cnt;

    // Down-counter is loaded during SETUP so it holds WAIT_STATES on ACCESS entry.
    assign pready  = (wait_cnt == 4'd0);
    assign prdata  = mem[paddr];
    assign pslverr = 1'b0;

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            wait_cnt <= 4'd0;
            for (int i = 0; i < SLV_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (psel && !penable) begin
                wait_cnt <= 4'(WAIT_STATES);
            end else if (psel && penable && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (psel && penable && pready && pwrite) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (pstrb[k]) begin
                        mem[paddr][8*k +: 8] <= pwdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/apb_multi_slave_subsystem.sv
// Command-driven APB master with address decoder, NUM_SLAVES memory slaves
// and an error responder for unmapped addresses.
// Ports:
//   apb_clk, apb_reset              : clock, synchronous active-high reset
//   cmd_valid / cmd_ready           : command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb : command fields, captured on accept
//   rsp_valid                       : one-cycle completion pulse
//   rsp_rdata, rsp_slverr           : read data (0 on writes/errors), error flag;
//                                     held until the next response
//
// state  | meaning
// IDLE   | no transfer; cmd_ready high
// SETUP  | psel asserted for the decoded slave, penable low
// ACCESS | penable high; waiting for pready from slave or error responder
module apb_multi_slave_subsystem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLV_DEPTH   = 32,
    parameter int WAIT_STATES = 1,
    parameter int BASE_ADDR   = 0
) (
    input  logic                    apb_clk,
    input  logic                    apb_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = clog2(NUM_SLAVES);
    localparam int OFF_W  = clog2(SLV_DEPTH);

    // One extra bit so an address below BASE_ADDR cannot wrap into the mapped range.
    localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] SPAN_EXT = (ADDR_WIDTH+1)'(NUM_SLAVES * SLV_DEPTH);

    apb_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_W-1:0]     pstrb;

    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    logic [ADDR_WIDTH:0]   off_ext;
    logic                  mapped;
    logic [SEL_W-1:0]      sel;
    logic [OFF_W-1:0]      word;

    logic [DATA_WIDTH-1:0] s_prdata [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] s_pready;
    logic [NUM_SLAVES-1:0] s_pslverr;

    logic accept;

    assign cmd_ready = (state == IDLE) && !apb_reset;
    assign accept    = cmd_valid && cmd_ready;

    // Decode from the captured address so it stays stable through ACCESS.
    assign off_ext = {1'b0, paddr} - BASE_EXT;
    assign mapped  = ({1'b0, paddr} >= BASE_EXT) && (off_ext < SPAN_EXT);
    assign sel     = off_ext[OFF_W +: SEL_W];
    assign word    = off_ext[OFF_W-1:0];

    assign penable = (state == ACCESS);

    always_comb begin
        psel = '0;
        if ((state != IDLE) && mapped) begin
            psel[sel] = 1'b1;
        end
    end

    // Unmapped accesses are answered by the error responder: ready at once, slverr set.
    always_comb begin
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = '0;
        if (mapped) begin
            pready  = s_pready[sel];
            pslverr = s_pslverr[sel];
            prdata  = s_prdata[sel];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            state  <= IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_strb;
            end
        end
    end

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (penable && pready) begin
                rsp_valid  <= 1'b1;
                rsp_slverr <= pslverr;
                rsp_rdata  <= (!pwrite && !pslverr) ? prdata : '0;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        apb_mem_slave #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SLV_DEPTH   (SLV_DEPTH),
            .WAIT_STATES (WAIT_STATES)
        ) u_slave (
            .apb_clk   (apb_clk),
            .apb_reset (apb_reset),
            .psel      (psel[i]),
            .penable   (penable),
            .pwrite    (pwrite),
            .paddr     (word),
            .pwdata    (pwdata),
            .pstrb     (pstrb),
            .prdata    (s_prdata[i]),
            .pready    (s_pready[i]),
            .pslverr   (s_pslverr[i])
        );
    end

endmodule

// File: doc/apb_multi_slave_subsystem.md
Name: apb_multi_slave_subsystem

Overview:
Parametrised successor to the single APB master/slave pair. A command-side valid/ready front end drives an internal APB master FSM (IDLE/SETUP/ACCESS). The FSM addresses NUM_SLAVES memory-backed APB slaves through an address decoder, with configurable wait states, byte strobes and error response on unmapped addresses. It sits between a testbench or CPU-side requester and the APB peripheral region.

Parameters:
ADDR_WIDTH, 10, word address width of cmd_addr and paddr
DATA_WIDTH, 32, data width; must be a multiple of 8
NUM_SLAVES, 4, number of slave instances (1..8)
SLV_DEPTH, 32, words per slave; power of 2
WAIT_STATES, 1, ACCESS-phase wait cycles inserted by every mapped slave (0..15)
BASE_ADDR, 0, word address of slave 0, word 0

Ports:
apb_clk  in  1  clock; all logic is on the rising edge
apb_reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  word address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte enables; ignored on reads
rsp_valid  out  1  one-cycle pulse: transfer complete
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
rsp_slverr  out  1  error flag, valid with rsp_valid

Behaviour:
- Reset (apb_reset high at a rising edge), all of the following:
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_slverr=0.
  - All slave memory words are cleared to 0.
  - Internal psel=0 and penable=0.
- cmd_ready = (state==IDLE) && !apb_reset. cmd_* inputs are ignored while cmd_ready=0. Command fields are registered at acceptance.
- FSM transitions:
  - IDLE -> SETUP on acceptance. In SETUP, psel[sel] is asserted (one-hot) and penable=0.
  - SETUP -> ACCESS unconditionally. In ACCESS, penable=1 and paddr, pwrite, pwdata, pstrb are held stable.
  - ACCESS -> IDLE at the edge where pready=1.
- Address decode:
  - off = cmd_addr - BASE_ADDR
  - sel = off / SLV_DEPTH
  - word = off % SLV_DEPTH
  - Unmapped when cmd_addr < BASE_ADDR or off >= NUM_SLAVES*SLV_DEPTH. In that case no psel is asserted, the decoder returns pready=1 in the first ACCESS cycle with pslverr=1, and no memory changes.
- Slave wait states: a wait counter is loaded with WAIT_STATES on ACCESS entry. pready=1 when the counter is 0; otherwise the counter decrements each cycle.
- Completing edge (penable && pready):
  - Write: memory byte lane k is updated only where pstrb[k]=1. strb=0 is a legal no-op with no error.
  - Read: prdata is captured into rsp_rdata.
  - rsp_valid goes to 1 for exactly one cycle, with rsp_slverr = pslverr.
- Latency:
  - Accept at edge E0 -> rsp_valid high after edge E0+2+WAIT_STATES for a mapped address, or after E0+2 for an unmapped one.
  - Next acceptance is possible at E0+3+WAIT_STATES at the earliest.
- No response backpressure.
- rsp_rdata and rsp_slverr hold their values until the next response.
- Reset mid-transfer: the transfer is aborted, no rsp_valid is produced, and no memory write happens even at the completing edge (reset has priority).

Decomposition:
- Shared package apb_pkg contains:
  - state enum {IDLE, SETUP, ACCESS}
  - localparams STRB_WIDTH = DATA_WIDTH/8, SEL_WIDTH = clog2(NUM_SLAVES), OFF_WIDTH = clog2(SLV_DEPTH)
  - clog2 function
- Sub-module apb_mem_slave, instanced NUM_SLAVES times via generate. Contents: memory, wait counter, strobe write, prdata/pready/pslverr (pslverr=0 always).
- The top level holds the FSM, decoder, response mux and error responder.

Test Plan:
- Reset, write 0xDEADBEEF to addr 5 with strb 0xF, then read addr 5 -> rsp_rdata=0xDEADBEEF, rsp_slverr=0, rsp_valid seen 3 cycles (WAIT_STATES=1) after the accepting edge.
- Write 0x11223344 to addr 40 (slave 1, word 8), then write 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
- Write and read addr 128 (unmapped, default parameters) -> rsp_slverr=1, rdata=0, response 2 cycles after accept; a read of addr 0 still returns the prior value.
- Write 0xA to addr 31 and 0xB to addr 32 (slave boundary) -> reads return 0xA and 0xB; psel stays one-hot, selecting slave 0 then slave 1.
- Hold cmd_valid high for 4 writes to addrs 0..3 -> one acceptance every 4 cycles, cmd_ready low in between, all 4 values read back correctly.
- Assert apb_reset during ACCESS of a write of 0x55 to addr 7 -> no rsp_valid, addr 7 reads 0, cmd_ready=1 the cycle after reset deasserts.
